pc_sequencer: RTL and testbench

- Issue-stage PC generator: owns the architectural fetch PC register, generalised over XLEN and reset vector.
- Adds a one-cycle redirect bubble FSM, issue-queue stall handshake and a return-address stack (RAS) that predicts jalr targets.
- Consumes the pipe_in fields and the committing ROB-head fields; drives fetch PC, flush, and the jalr predicted target carried into the ROB.

---
 rtl/pc_sequencer_pkg.sv | 35 +++
 rtl/pc_sequencer_if.sv | 59 +++++
 rtl/pc_sequencer_ras_stack.sv | 74 +++++++
 rtl/pc_sequencer.sv | 173 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared types, link-register constants and RISC-V immediate
//               decoders used by the PC sequencer and its RAS.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } pc_state_e;

  // Registers treated as return-address links by the RAS hints
  localparam logic [4:0] c_LINK_X1 = 5'd1;
  localparam logic [4:0] c_LINK_X5 = 5'd5;

  // B-type immediate, sign-extended to 32 bits
  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  // J-type immediate, sign-extended to 32 bits
  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic is_link(input logic [4:0] r);
    return (r == c_LINK_X1) || (r == c_LINK_X5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Pipe-in / ROB-commit / fetch bundle between the issue stage
//               and the PC sequencer. master = upstream, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  import pc_sequencer_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instruction;
    logic            branch;
    logic            jump;
    logic            prediction;
  } pipe_in_t;

  // pipe side
  logic            issue_ready;
  logic            pipe_valid;
  pipe_in_t        pipe_in;
  logic            pipe_jalr;
  // ROB head commit side
  logic            commit_valid;
  logic            commit_is_branch;
  logic            commit_taken;
  logic            commit_result;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] commit_imm_se;
  logic            commit_jalr;
  logic [XLEN-1:0] jalr_taken_address;
  logic [XLEN-1:0] jalr_actual_address;
  // sequencer results
  logic [XLEN-1:0] pc;
  logic            fetch_valid;
  logic            mispredicted;
  logic [XLEN-1:0] jalr_pred_addr;

  modport master (
    output issue_ready, pipe_valid, pipe_in, pipe_jalr,
    output commit_valid, commit_is_branch, commit_taken, commit_result,
    output commit_pc, commit_imm_se, commit_jalr,
    output jalr_taken_address, jalr_actual_address,
    input  pc, fetch_valid, mispredicted, jalr_pred_addr
  );

  modport slave (
    input  issue_ready, pipe_valid, pipe_in, pipe_jalr,
    input  commit_valid, commit_is_branch, commit_taken, commit_result,
    input  commit_pc, commit_imm_se, commit_jalr,
    input  jalr_taken_address, jalr_actual_address,
    output pc, fetch_valid, mispredicted, jalr_pred_addr
  );

endinterface
`default_nettype wire

// File: rtl/pc_sequencer_ras_stack.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack
// Description : Circular return-address stack. A push onto a full stack
//               overwrites the oldest entry; a pop on empty is a no-op.
//               push+pop together replaces the top entry.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack
  import pc_sequencer_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            i_push,
  input  wire logic            i_pop,
  input  wire logic            i_clear,
  input  wire logic [XLEN-1:0] i_push_data,
  output logic      [XLEN-1:0] o_top,
  output logic                 o_empty
);

  localparam int c_PTR_W = $clog2(RAS_DEPTH);
  localparam int c_CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]    r_mem [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_ptr;     // index of the current top entry
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] w_ptr_inc;
  logic [c_PTR_W-1:0] w_wr_idx;
  logic               w_replace;

  assign w_ptr_inc = r_ptr + 1'b1;
  // Pop-then-push on a non-empty stack rewrites the top slot in place;
  // on an empty stack the pop is void and it degenerates to a plain push.
  assign w_replace = i_pop && (r_count != '0);
  assign w_wr_idx  = w_replace ? r_ptr : w_ptr_inc;
  assign o_top     = r_mem[r_ptr];
  assign o_empty   = (r_count == '0);

  // Pointer and occupancy tracking; clear empties the stack
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push && i_pop) begin
      if (r_count == '0) begin
        r_ptr   <= w_ptr_inc;
        r_count <= c_CNT_W'(1);
      end
    end else if (i_push) begin
      r_ptr <= w_ptr_inc;
      if (r_count != c_CNT_W'(RAS_DEPTH)) begin
        r_count <= r_count + 1'b1;
      end
    end else if (i_pop) begin
      if (r_count != '0) begin
        r_ptr   <= r_ptr - 1'b1;
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Entry storage; contents are only observed while the stack is non-empty
  always_ff @(posedge clk) begin
    if (!rst && !i_clear && i_push) begin
      r_mem[w_wr_idx] <= i_push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Issue-stage fetch PC generator with redirect bubble FSM,
//               issue-queue stall handshake and RAS-based jalr prediction.
//               Optional macro PC_PERF_CTR_EN builds a 32-bit mispredict
//               counter; otherwise o_mispredict_count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 8
) (
  input  wire logic   clk,
  input  wire logic   reset,
  pc_sequencer_if.slave bus,
  output logic [31:0] o_mispredict_count
);

  pc_state_e       r_state;
  pc_state_e       w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;

  logic            w_br_mis;
  logic            w_jalr_mis;
  logic            w_mis;
  logic [XLEN-1:0] w_redirect_target;
  logic            w_accept;

  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_take_branch;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic            w_rd_link;
  logic            w_rs1_link;
  logic            w_ras_push;
  logic            w_ras_pop;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic [XLEN-1:0] w_pred_raw;
  logic [XLEN-1:0] w_pred;
  logic            w_unused_opcode;

  // ---- commit-side misprediction detect ----
  assign w_br_mis   = bus.commit_is_branch & (bus.commit_taken ^ bus.commit_result);
  assign w_jalr_mis = bus.commit_jalr & (bus.jalr_taken_address != bus.jalr_actual_address);
  assign w_mis      = bus.commit_valid & (w_br_mis | w_jalr_mis);

  // Redirect target; a branch mispredict outranks a jalr mispredict
  always_comb begin
    w_redirect_target = {bus.jalr_actual_address[XLEN-1:1], 1'b0};
    if (w_br_mis) begin
      w_redirect_target = bus.commit_taken ? (bus.commit_pc + XLEN'(4))
                                           : (bus.commit_pc + bus.commit_imm_se);
    end
  end

  // ---- pipe-side decode ----
  assign w_imm_b         = XLEN'($signed(imm_b(bus.pipe_in.instruction)));
  assign w_imm_j         = XLEN'($signed(imm_j(bus.pipe_in.instruction)));
  assign w_pc_plus4      = r_pc + XLEN'(4);
  assign w_rd            = bus.pipe_in.instruction[11:7];
  assign w_rs1           = bus.pipe_in.instruction[19:15];
  assign w_rd_link       = is_link(w_rd);
  assign w_rs1_link      = is_link(w_rs1);
  assign w_unused_opcode = ^bus.pipe_in.instruction[6:0];

  assign w_take_branch = bus.pipe_in.branch & bus.pipe_in.prediction;
  assign w_is_jal      = ~w_take_branch & bus.pipe_in.jump;
  assign w_is_jalr     = ~w_take_branch & ~bus.pipe_in.jump & bus.pipe_jalr;

  assign w_accept = (r_state == RUN) & bus.pipe_valid & bus.issue_ready & ~w_mis;

  // RAS hint table: push on link rd, pop on link rs1 unless it is the same link as rd
  assign w_ras_push = w_accept & (w_is_jal | w_is_jalr) & w_rd_link;
  assign w_ras_pop  = w_accept & w_is_jalr & w_rs1_link & (~w_rd_link | (w_rd != w_rs1));

  assign w_pred_raw = w_ras_empty ? (bus.pipe_in.pc + XLEN'(4)) : w_ras_top;
  assign w_pred     = {w_pred_raw[XLEN-1:1], 1'b0};

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (reset),
    .i_push      (w_ras_push),
    .i_pop       (w_ras_pop),
    .i_clear     (w_mis),
    .i_push_data (w_pc_plus4),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty)
  );

  // Next fetch PC: redirect beats everything, else advance only on accept
  always_comb begin
    w_pc_next = r_pc;
    if (w_mis) begin
      w_pc_next = w_redirect_target;
    end else if (w_accept) begin
      if (w_take_branch) begin
        w_pc_next = r_pc + w_imm_b;
      end else if (bus.pipe_in.jump) begin
        w_pc_next = r_pc + w_imm_j;
      end else if (bus.pipe_jalr) begin
        w_pc_next = w_pred;
      end else begin
        w_pc_next = w_pc_plus4;
      end
    end
  end

  // Fetch PC register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // FSM next-state: one boot cycle, one bubble per redirect
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT:     w_state_next = RUN;
      RUN:      w_state_next = w_mis ? REDIRECT : RUN;
      REDIRECT: w_state_next = w_mis ? REDIRECT : RUN;
      default:  w_state_next = BOOT;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign bus.pc             = r_pc;
  assign bus.fetch_valid    = (r_state == RUN);
  assign bus.mispredicted   = w_mis;
  assign bus.jalr_pred_addr = w_pred;

`ifdef PC_PERF_CTR_EN
  logic [31:0] r_mispredict_count;

  // Count every cycle a flush is signalled; wraps silently
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mispredict_count <= 32'd0;
    end else if (w_mis) begin
      r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign o_mispredict_count = r_mispredict_count;
`else
  assign o_mispredict_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer: directed scenarios and
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int              XLEN      = 32;
  localparam int              RAS_DEPTH = 8;
  localparam logic [XLEN-1:0] RESET_PC  = '0;

  typedef enum int {K_ALU, K_BR, K_JAL, K_JALR} kind_e;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mispredict_count;

  always #5 clk = ~clk;

  pc_sequencer_if #(.XLEN(XLEN)) bus ();

  pc_sequencer #(
    .XLEN      (XLEN),
    .RESET_PC  (RESET_PC),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .o_mispredict_count (mispredict_count)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int              m_phase;   // 0 boot, 1 running, 2 redirect bubble
  logic [XLEN-1:0] m_pc;
  logic [XLEN-1:0] m_ras[$];
  logic [31:0]     m_cnt;
  kind_e           s_kind;
  int              s_imm, s_rd, s_rs1;
  bit              s_pred;

  function automatic bit m_link(input int r);
    return (r == 1) || (r == 5);
  endfunction

  function automatic bit m_br_wrong();
    return bus.commit_is_branch && (bus.commit_taken != bus.commit_result);
  endfunction

  function automatic bit m_mis();
    bit jr;
    jr = bus.commit_jalr && (bus.jalr_taken_address != bus.jalr_actual_address);
    return bus.commit_valid && (m_br_wrong() || jr);
  endfunction

  function automatic logic [XLEN-1:0] m_target();
    logic [XLEN-1:0] t;
    if (m_br_wrong())
      t = bus.commit_taken ? bus.commit_pc + 4 : bus.commit_pc + bus.commit_imm_se;
    else begin
      t = bus.jalr_actual_address;
      t[0] = 1'b0;
    end
    return t;
  endfunction

  function automatic logic [XLEN-1:0] m_pred();
    logic [XLEN-1:0] a;
    a = (m_ras.size() > 0) ? m_ras[$] : bus.pipe_in.pc + 4;
    a[0] = 1'b0;
    return a;
  endfunction

  task automatic ras_push(input logic [XLEN-1:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
  endtask

  task automatic model_edge();
    bit mis, acc;
    logic [XLEN-1:0] tgt;
    if (reset) begin
      m_pc = RESET_PC; m_phase = 0; m_ras.delete(); m_cnt = 0;
      return;
    end
    mis = m_mis();
    acc = (m_phase == 1) && bus.pipe_valid && bus.issue_ready && !mis;
    if (mis) begin
      m_cnt++;
      m_pc = m_target();
      m_ras.delete();
    end else if (acc) begin
      case (s_kind)
        K_BR:  m_pc = s_pred ? m_pc + XLEN'(s_imm) : m_pc + 4;
        K_JAL: begin
          if (m_link(s_rd)) ras_push(m_pc + 4);
          m_pc = m_pc + XLEN'(s_imm);
        end
        K_JALR: begin
          tgt = m_pred();
          if (m_link(s_rs1) && (!m_link(s_rd) || s_rd != s_rs1) && m_ras.size() > 0)
            void'(m_ras.pop_back());
          if (m_link(s_rd)) ras_push(m_pc + 4);
          m_pc = tgt;
        end
        default: m_pc = m_pc + 4;
      endcase
    end
    m_phase = (m_phase == 0) ? 1 : (mis ? 2 : 1);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_pipe(input kind_e k, input int imm, input int rd, input int rs1,
                            input bit pred, input bit valid, input bit ready);
    logic [31:0] ins;
    logic [12:0] b;
    logic [20:0] j;
    s_kind = k; s_imm = imm; s_rd = rd; s_rs1 = rs1; s_pred = pred;
    b = imm[12:0];
    j = imm[20:0];
    case (k)
      K_BR:    ins = {b[12], b[10:5], 5'd2, 5'(rs1), 3'b000, b[4:1], b[11], 7'b1100011};
      K_JAL:   ins = {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'b1101111};
      K_JALR:  ins = {12'h000, 5'(rs1), 3'b000, 5'(rd), 7'b1100111};
      default: ins = {12'h001, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endcase
    bus.pipe_in.pc          = m_pc;
    bus.pipe_in.instruction = ins;
    bus.pipe_in.branch      = (k == K_BR);
    bus.pipe_in.prediction  = (k == K_BR) && pred;
    bus.pipe_in.jump        = (k == K_JAL);
    bus.pipe_jalr           = (k == K_JALR);
    bus.pipe_valid          = valid;
    bus.issue_ready         = ready;
  endtask

  task automatic drive_commit(input bit cv, input bit cb, input bit ct, input bit cr,
                              input logic [XLEN-1:0] cpc, input logic [XLEN-1:0] cimm,
                              input bit cj, input logic [XLEN-1:0] jta,
                              input logic [XLEN-1:0] jaa);
    bus.commit_valid        = cv;
    bus.commit_is_branch    = cb;
    bus.commit_taken        = ct;
    bus.commit_result       = cr;
    bus.commit_pc           = cpc;
    bus.commit_imm_se       = cimm;
    bus.commit_jalr         = cj;
    bus.jalr_taken_address  = jta;
    bus.jalr_actual_address = jaa;
  endtask

  task automatic commit_idle();
    drive_commit(0, 0, 0, 0, '0, '0, 0, '0, '0);
  endtask

  // One clock: check outputs mid-cycle, advance DUT and model together
  task automatic cycle();
    logic [31:0] exp_cnt;
    bus.pipe_in.pc = m_pc;
    #1;
    check_val("pc", bus.pc, m_pc);
    check_val("fetch_valid", bus.fetch_valid, m_phase == 1);
    check_val("mispredicted", bus.mispredicted, m_mis());
    check_val("jalr_pred_addr", bus.jalr_pred_addr, m_pred());
`ifdef PC_PERF_CTR_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 32'd0;
`endif
    check_val("mispredict_count", mispredict_count, exp_cnt);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Force the PC to addr through a jalr mispredict, then leave the bubble
  task automatic redirect_to(input logic [XLEN-1:0] addr);
    drive_pipe(K_ALU, 0, 0, 0, 0, 0, 1);
    drive_commit(1, 0, 0, 0, '0, '0, 1, addr ^ 32'h10, addr);
    cycle();
    commit_idle();
    cycle();
  endtask

  function automatic int pick_reg();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 1;
    if (r == 1) return 5;
    if (r == 2) return 0;
    return $urandom_range(0, 31);
  endfunction

  initial begin
    logic [XLEN-1:0] rets [9];
    logic [XLEN-1:0] exp_ret;
    logic [31:0]     cnt_exp;
    logic [XLEN-1:0] ja;

    reset = 1'b1;
    commit_idle();
    m_pc = RESET_PC;
    drive_pipe(K_ALU, 0, 3, 3, 0, 1, 1);
    @(negedge clk);
    do_reset();

    // sequential fetch after reset
    drive_pipe(K_ALU, 0, 3, 3, 0, 1, 1);
    check_val("t1_pc_boot", bus.pc, 32'h0);
    check_val("t1_fv_boot", bus.fetch_valid, 1'b0);
    cycle();
    check_val("t1_pc_run0", bus.pc, 32'h0);
    check_val("t1_fv_run0", bus.fetch_valid, 1'b1);
    cycle();
    check_val("t1_pc_4", bus.pc, 32'h4);
    cycle();
    check_val("t1_pc_8", bus.pc, 32'h8);

    // stall on a predicted-taken branch
    redirect_to(32'h100);
    drive_pipe(K_BR, -8, 0, 0, 1, 1, 0);
    cycle();
    check_val("t2_hold1", bus.pc, 32'h100);
    cycle();
    check_val("t2_hold2", bus.pc, 32'h100);
    drive_pipe(K_BR, -8, 0, 0, 1, 1, 1);
    cycle();
    check_val("t2_branch", bus.pc, 32'hF8);

    // commit branch mispredict while the queue is full
    drive_pipe(K_ALU, 0, 0, 0, 0, 1, 0);
    drive_commit(1, 1, 0, 1, 32'h40, 32'h20, 0, '0, '0);
    #1;
    check_val("t3_mis", bus.mispredicted, 1'b1);
    cycle();
    check_val("t3_pc", bus.pc, 32'h60);
    check_val("t3_fv", bus.fetch_valid, 1'b0);
    commit_idle();
    drive_pipe(K_JALR, 0, 0, 1, 0, 1, 0);
    #1;
    check_val("t3_ras_empty", bus.jalr_pred_addr, 32'h64);
    cycle();
    check_val("t3_fv_back", bus.fetch_valid, 1'b1);

    // call then return
    redirect_to(32'h200);
    drive_pipe(K_JAL, 32'h100, 1, 0, 0, 1, 1);
    cycle();
    drive_pipe(K_JALR, 0, 0, 1, 0, 1, 1);
    #1;
    check_val("t4_pred", bus.jalr_pred_addr, 32'h204);
    cycle();
    check_val("t4_pc", bus.pc, 32'h204);

    // overflow the RAS by one call
    redirect_to(32'h1000);
    for (int i = 0; i < 9; i++) begin
      rets[i] = m_pc + 4;
      drive_pipe(K_JAL, 32'h40, 1, 0, 0, 1, 1);
      cycle();
    end
    for (int i = 0; i < 9; i++) begin
      drive_pipe(K_JALR, 0, 0, 1, 0, 1, 1);
      #1;
      exp_ret = (i < 8) ? rets[8 - i] : m_pc + 4;
      check_val("t5_ret", bus.jalr_pred_addr, exp_ret);
      cycle();
    end

    // jalr mispredict and the perf counter
    commit_idle();
    drive_pipe(K_ALU, 0, 0, 0, 0, 0, 1);
    do_reset();
    cycle();
    drive_commit(1, 0, 0, 0, '0, '0, 1, 32'h300, 32'h305);
    cycle();
    check_val("t6_pc", bus.pc, 32'h304);
    commit_idle();
`ifdef PC_PERF_CTR_EN
    cnt_exp = 32'd1;
`else
    cnt_exp = 32'd0;
`endif
    check_val("t6_count", mispredict_count, cnt_exp);
    cycle();

    // silent wrap-around of the PC
    redirect_to(32'hFFFF_FFFC);
    drive_pipe(K_ALU, 0, 0, 0, 0, 1, 1);
    cycle();
    check_val("t7_wrap", bus.pc, 32'h0);

    // reset while a redirect is pending
    drive_commit(1, 0, 0, 0, '0, '0, 1, 32'h0, 32'h500);
    cycle();
    drive_commit(1, 0, 0, 0, '0, '0, 1, 32'h0, 32'h700);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    commit_idle();
    check_val("t8_pc", bus.pc, RESET_PC);
    check_val("t8_fv", bus.fetch_valid, 1'b0);

    // randomized traffic
    for (int c = 0; c < 1200; c++) begin
      int    r, imm;
      kind_e k;
      r = $urandom_range(0, 99);
      if (r < 30)      begin k = K_ALU;  imm = 0; end
      else if (r < 50) begin k = K_BR;   imm = (int'($urandom_range(0, 4095)) - 2048) * 2; end
      else if (r < 75) begin k = K_JAL;  imm = (int'($urandom_range(0, 2047)) - 1024) * 4; end
      else             begin k = K_JALR; imm = 0; end
      drive_pipe(k, imm, pick_reg(), pick_reg(), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0);
      ja = $urandom() & 32'hFFFF_FFFC;
      drive_commit($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom() & 32'hFFFF_FFFC,
                   XLEN'((int'($urandom_range(0, 4095)) - 2048) * 2),
                   1'($urandom_range(0, 1)), ja,
                   ($urandom_range(0, 3) == 0) ? ja ^ XLEN'($urandom_range(1, 255)) : ja);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
